// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding and tick constants.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;

  // Tick index inside the start bit at which the line is re-checked (centre of the bit).
  function automatic int mid_tick(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
// Latency SYNC_STAGES clocks, no backpressure.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver on a 16x sample tick with a one-entry VALID/READY holding register; byte is valid
// the cycle after the stop-bit sample, a full unaccepted register drops new bytes (OVERRUN). Parity: UART_RX_PARITY_EN.
module uart_rx_oversample
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BDSAM,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(mid_tick(OVERSAMPLE));
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rxd_s;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (RXD),
    .q  (rxd_s)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver;
  logic                 stop_bad;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic perr_hold_q, perr_hold_d;
`endif

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    deliver  = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = perr_q;
`endif
    if (BDSAM) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end
        ST_START: begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            perr_d  = (^shift_q) ^ rxd_s;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            deliver  = 1'b1;
            stop_bad = !rxd_s;
            // A low stop bit means the line may stay low; park until it rises.
            state_d  = rxd_s ? ST_IDLE : ST_BREAK;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        ST_BREAK: begin
          if (rxd_s) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    accept  = valid_q & RX_READY;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    perr_hold_d = perr_hold_q;
`endif
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        ferr_d  = stop_bad;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        perr_hold_d = perr_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perr_q      <= 1'b0;
      perr_hold_q <= 1'b0;
    end else begin
      perr_q      <= perr_d;
      perr_hold_q <= perr_hold_d;
    end
  end
  assign PARITY_ERR = perr_hold_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

  assign RX_DATA   = data_q;
  assign RX_VALID  = valid_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed frames plus randomized traffic against a byte-queue model.
module tb_uart_rx_oversample;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          BDSAM;
  logic          RXD;
  logic [DB-1:0] RX_DATA;
  logic          RX_VALID;
  logic          RX_READY;
  logic          FRAME_ERR;
  logic          PARITY_ERR;
  logic          OVERRUN;
  logic          BUSY;

  always #5 CLK = ~CLK;

  uart_rx_oversample #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BDSAM     (BDSAM),
    .RXD       (RXD),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .FRAME_ERR (FRAME_ERR),
    .PARITY_ERR(PARITY_ERR),
    .OVERRUN   (OVERRUN),
    .BUSY      (BUSY)
  );

  typedef struct packed {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rdy_rand = 1'b0;
  logic rdy_dir  = 1'b1;
  logic chk_ovr  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // What the receiver must report for a frame, straight from the line contents.
  function automatic exp_t model(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
    exp_t e;
    e.data = d;
    e.ferr = ~stop_b;
    e.perr = PAR_EN ? ((^d) ^ par_b) : 1'b0;
    return e;
  endfunction

  initial begin
    BDSAM = 1'b0;
    forever begin
      for (int i = 0; i < TICK_DIV; i++) begin
        @(posedge CLK);
        #1 BDSAM = (i == TICK_DIV - 1);
      end
    end
  end

  initial begin
    RX_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #2 RX_READY = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_dir;
    end
  end

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (RX_VALID && RX_READY) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, no byte expected", RX_DATA);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("model_data", RX_DATA, e.data);
          check("model_frame_err", FRAME_ERR, e.ferr);
          check("model_parity_err", PARITY_ERR, e.perr);
        end
      end
      if (chk_ovr) check("model_overrun", OVERRUN, 0);
    end
  end

  task automatic send_bit(input logic b, input int ticks);
    RXD = b;
    repeat (ticks * TICK_DIV) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b,
                            input bit push);
    if (push) exp_q.push_back(model(d, stop_b, par_b));
    send_bit(1'b0, OS);
    for (int i = 0; i < DB; i++) send_bit(d[i], OS);
    if (PAR_EN) send_bit(par_b, OS);
    send_bit(stop_b, OS);
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 14 * BIT_CLK; i++) begin
      @(negedge CLK);
      if (RX_VALID) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: RX_VALID never rose, expected 1", name);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int busy_cnt;
    RST = 1'b1;
    RXD = 1'b1;
    repeat (5) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_data", RX_DATA, 0);
    check("reset_valid", RX_VALID, 0);
    check("reset_frame_err", FRAME_ERR, 0);
    check("reset_parity_err", PARITY_ERR, 0);
    check("reset_overrun", OVERRUN, 0);
    check("reset_busy", BUSY, 0);
    @(posedge CLK);
    #1;
    send_bit(1'b1, OS);

    fork
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      begin
        wait_valid("t55_valid", ok);
        if (ok) begin
          check("t55_data", RX_DATA, 8'h55);
          check("t55_frame_err", FRAME_ERR, 0);
          check("t55_overrun", OVERRUN, 0);
          @(negedge CLK);
          check("t55_valid_one_cycle", RX_VALID, 0);
        end
      end
    join
    send_bit(1'b1, OS);

    busy_cnt = 0;
    fork
      begin
        send_bit(1'b0, 3);
        RXD = 1'b1;
      end
      for (int i = 0; i < 3 * BIT_CLK; i++) begin
        @(negedge CLK);
        if (BUSY) busy_cnt++;
      end
    join
    check("glitch_busy_cycles", busy_cnt, 32);
    check("glitch_busy_end", BUSY, 0);
    @(posedge CLK);
    #1;

    fork
      send_frame(8'hA3, 1'b0, 1'b0, 1'b1);
      begin
        wait_valid("ta3_valid", ok);
        if (ok) begin
          check("ta3_data", RX_DATA, 8'hA3);
          check("ta3_frame_err", FRAME_ERR, 1);
        end
      end
    join
    send_bit(1'b0, OS);
    @(negedge CLK);
    check("break_busy_low_line", BUSY, 1);
    @(posedge CLK);
    #1;
    send_bit(1'b1, OS);
    @(negedge CLK);
    check("break_idle_after_high", BUSY, 0);
    @(posedge CLK);
    #1;

    rdy_dir = 1'b0;
    chk_ovr = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 2);
    @(negedge CLK);
    check("ovr_valid", RX_VALID, 1);
    check("ovr_data_kept", RX_DATA, 8'h11);
    check("ovr_flag", OVERRUN, 1);
    @(posedge CLK);
    #1 rdy_dir = 1'b1;
    @(posedge CLK);
    #1 rdy_dir = 1'b0;
    @(negedge CLK);
    check("ovr_accept_valid", RX_VALID, 0);
    check("ovr_accept_clear", OVERRUN, 0);
    @(posedge CLK);
    #1 rdy_dir = 1'b1;
    chk_ovr = 1'b1;
    send_bit(1'b1, OS);

    send_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) send_bit(1'b0, OS);
    send_bit(1'b1, OS / 2);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_data", RX_DATA, 0);
    check("rst_mid_valid", RX_VALID, 0);
    check("rst_mid_frame_err", FRAME_ERR, 0);
    check("rst_mid_parity_err", PARITY_ERR, 0);
    check("rst_mid_overrun", OVERRUN, 0);
    check("rst_mid_busy", BUSY, 0);
    @(posedge CLK);
    #1;
    send_bit(1'b1, 5 * OS);
    fork
      send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
      begin
        wait_valid("t0f_valid", ok);
        if (ok) check("t0f_data", RX_DATA, 8'h0F);
      end
    join
    send_bit(1'b1, OS);

`ifdef UART_RX_PARITY_EN
    fork
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      begin
        wait_valid("par0_valid", ok);
        if (ok) check("par0_parity_err", PARITY_ERR, 1);
      end
    join
    send_bit(1'b1, OS);
    fork
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      begin
        wait_valid("par1_valid", ok);
        if (ok) check("par1_parity_err", PARITY_ERR, 0);
      end
    join
    send_bit(1'b1, OS);
`endif

    rdy_rand = 1'b1;
    for (int n = 0; n < 25; n++) begin
      logic [DB-1:0] d;
      logic          stop_b;
      logic          par_b;
      int            gap;
      d      = DB'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      par_b  = 1'($urandom_range(0, 1));
      send_frame(d, stop_b, par_b, 1'b1);
      RXD = 1'b1;
      gap = stop_b ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if (gap > 0) send_bit(1'b1, gap * OS);
    end
    rdy_rand = 1'b0;
    rdy_dir  = 1'b1;
    send_bit(1'b1, 2 * OS);
    @(negedge CLK);
    check("final_queue_drained", exp_q.size(), 0);
    check("final_valid", RX_VALID, 0);
    check("final_busy", BUSY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
